// File: rtl/bit_serializer_piso_pkg.sv
// Shared types and default constants for the parallel-in/serial-out serializer.
// Imported by the top and by its counter sub-module.
package bit_serializer_piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int   DEFAULT_WIDTH    = 8;
  localparam int   DEFAULT_CNT_W    = 16;
  localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/bit_serializer_counter.sv
// Bit position counter with last-bit decode, plus the wrapping sent-word counter.
// The bit counter restarts on every word load; the word counter steps on each completed word.
module bit_serializer_counter
  import bit_serializer_piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr_i,
  input  logic                       inc_i,
  input  logic                       word_done_i,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt_o,
  output logic                       last_bit_o,
  output logic [CNT_W-1:0]           words_sent_o
);

  localparam int BW = $clog2(WIDTH);

  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] words_q, words_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (clr_i) begin
      bit_cnt_d = '0;
    end else if (inc_i) begin
      bit_cnt_d = bit_cnt_q + BW'(1);
    end
    // Natural modulo-2^CNT_W wrap.
    words_d = word_done_i ? (words_q + CNT_W'(1)) : words_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
      words_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      words_q   <= words_d;
    end
  end

  assign bit_cnt_o    = bit_cnt_q;
  assign last_bit_o   = (bit_cnt_q == BW'(WIDTH - 1));
  assign words_sent_o = words_q;

endmodule

// File: rtl/bit_serializer_piso.sv
// Parallel-in/serial-out stage feeding a serial sequence detector.
// Words are accepted on valid/ready and shifted out one bit per bit_tick, gapless back-to-back.
module bit_serializer_piso
  import bit_serializer_piso_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT,
  parameter int   CNT_W     = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              bit_tick,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int BW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted;
  logic             cur_bit;
  logic             cnt_clr, cnt_inc, word_done, last_bit;
  logic [BW-1:0]    bit_cnt;

  // The output end of the shift register is fixed at elaboration time.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign cur_bit = shreg_q[WIDTH-1];
      assign shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign cur_bit = shreg_q[0];
      assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    word_done  = 1'b0;
    data_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        data_ready = 1'b1;
        if (data_valid) begin
          shreg_d = data_in;
          cnt_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_tick) begin
          if (last_bit) begin
            // Last bit leaves this cycle: reload in place to avoid an idle gap.
            word_done  = 1'b1;
            data_ready = 1'b1;
            cnt_clr    = 1'b1;
            if (data_valid) begin
              shreg_d = data_in;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            shreg_d = shifted;
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) begin
      data_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  bit_serializer_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (cnt_clr),
    .inc_i        (cnt_inc),
    .word_done_i  (word_done),
    .bit_cnt_o    (bit_cnt),
    .last_bit_o   (last_bit),
    .words_sent_o (words_sent)
  );

  assign ser_valid   = (state_q == ST_SHIFT);
  assign ser_out     = ser_valid ? cur_bit : IDLE_BIT;
  assign frame_start = ser_valid && (bit_cnt == '0);
  assign frame_end   = ser_valid && last_bit;

endmodule

// File: tb/tb_bit_serializer_piso.sv
// Self-checking bench: MSB-first, LSB-first and narrow-counter instances share one stimulus stream.
// Table-driven vectors cover single/back-to-back words; hand sequences cover gapped tick, reset and wrap.
module tb_bit_serializer_piso;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       data_valid;
  logic       bit_tick;
  logic [7:0] data_in;

  logic        m_ready, m_ser, m_sv, m_fs, m_fe;
  logic [15:0] m_ws;
  logic        l_ready, l_ser, l_sv, l_fs, l_fe;
  logic [15:0] l_ws;
  logic        w_ready, w_ser, w_sv, w_fs, w_fe;
  logic [3:0]  w_ws;

  bit_serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(m_ready), .bit_tick(bit_tick), .ser_out(m_ser), .ser_valid(m_sv),
    .frame_start(m_fs), .frame_end(m_fe), .words_sent(m_ws));

  bit_serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(16)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(l_ready), .bit_tick(bit_tick), .ser_out(l_ser), .ser_valid(l_sv),
    .frame_start(l_fs), .frame_end(l_fe), .words_sent(l_ws));

  bit_serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(4)) u_wrap (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(w_ready), .bit_tick(bit_tick), .ser_out(w_ser), .ser_valid(w_sv),
    .frame_start(w_fs), .frame_end(w_fe), .words_sent(w_ws));

  typedef struct {
    logic        clr;
    logic        valid;
    logic        tick;
    logic [7:0]  din;
    logic        rdy;
    logic        sv;
    logic        ser;
    logic        lsb;
    logic        fs;
    logic        fe;
    logic        y;
    logic [15:0] ws;
  } vec_t;

  int total_cnt = 0;
  int pass_cnt  = 0;

  function automatic vec_t mk(input logic clr, input logic valid, input logic tick,
                              input logic [7:0] din, input logic rdy, input logic sv,
                              input logic ser, input logic lsb, input logic fs,
                              input logic fe, input logic y, input logic [15:0] ws);
    vec_t v;
    v.clr = clr; v.valid = valid; v.tick = tick; v.din = din;
    v.rdy = rdy; v.sv = sv; v.ser = ser; v.lsb = lsb;
    v.fs = fs; v.fe = fe; v.y = y; v.ws = ws;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       vecs[$];
    logic [2:0] det_hist;
    logic       det_y;

    // {clr, valid, tick, din, rdy, sv, ser(msb), ser(lsb), fs, fe, y, words_sent}
    // 0xA5 MSB-first (LSB-first stream is identical for this word)
    vecs.push_back(mk(1,1,1,8'hA5, 1,0,0,0,0,0,0,16'd0));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,1,1,1,0,0,16'd0));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,0,0,0,0,0,16'd0));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,1,1,0,0,0,16'd0));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,0,0,0,0,1,16'd0));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,0,0,0,0,0,16'd0));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,1,1,0,0,0,16'd0));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,0,0,0,0,0,16'd0));
    vecs.push_back(mk(0,0,1,8'h00, 1,1,1,1,0,1,0,16'd0));
    vecs.push_back(mk(0,0,1,8'h00, 1,0,0,0,0,0,0,16'd1));
    // 0x0A then 0x0A back to back, data_valid held high through the first word
    vecs.push_back(mk(1,1,1,8'h0A, 1,0,0,0,0,0,0,16'd1));
    vecs.push_back(mk(0,1,1,8'h0A, 0,1,0,0,1,0,0,16'd1));
    vecs.push_back(mk(0,1,1,8'h0A, 0,1,0,1,0,0,0,16'd1));
    vecs.push_back(mk(0,1,1,8'h0A, 0,1,0,0,0,0,0,16'd1));
    vecs.push_back(mk(0,1,1,8'h0A, 0,1,0,1,0,0,0,16'd1));
    vecs.push_back(mk(0,1,1,8'h0A, 0,1,1,0,0,0,0,16'd1));
    vecs.push_back(mk(0,1,1,8'h0A, 0,1,0,0,0,0,0,16'd1));
    vecs.push_back(mk(0,1,1,8'h0A, 0,1,1,0,0,0,0,16'd1));
    vecs.push_back(mk(0,1,1,8'h0A, 1,1,0,0,0,1,1,16'd1));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,0,0,1,0,0,16'd2));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,0,1,0,0,0,16'd2));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,0,0,0,0,0,16'd2));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,0,1,0,0,0,16'd2));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,1,0,0,0,0,16'd2));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,0,0,0,0,0,16'd2));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,1,0,0,0,0,16'd2));
    vecs.push_back(mk(0,0,1,8'h00, 1,1,0,0,0,1,1,16'd2));
    vecs.push_back(mk(0,0,1,8'h00, 1,0,0,0,0,0,0,16'd3));
    // 0x01: MSB-first ends with the 1, LSB-first starts with it
    vecs.push_back(mk(1,1,1,8'h01, 1,0,0,0,0,0,0,16'd3));
    vecs.push_back(mk(0,0,1,8'h00, 0,1,0,1,1,0,0,16'd3));
    for (int k = 0; k < 6; k++) vecs.push_back(mk(0,0,1,8'h00, 0,1,0,0,0,0,0,16'd3));
    vecs.push_back(mk(0,0,1,8'h00, 1,1,1,0,0,1,0,16'd3));
    vecs.push_back(mk(0,0,1,8'h00, 1,0,0,0,0,0,0,16'd4));

    reset = 1'b1; data_valid = 1'b0; bit_tick = 1'b1; data_in = 8'h00;
    det_hist = 3'b000;

    // Reset state
    cyc();
    #2;
    chk("reset ready low", m_ready, 1'b0);
    chk("reset ser_valid", m_sv, 1'b0);
    chk("reset ser_out", m_ser, 1'b0);
    chk("reset words_sent", m_ws, 16'd0);
    cyc();
    reset = 1'b0;
    #2;
    chk("post-reset ready", m_ready, 1'b1);
    chk("post-reset frame_start", m_fs, 1'b0);
    chk("post-reset frame_end", m_fe, 1'b0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      cyc();
      data_valid = v.valid; bit_tick = v.tick; data_in = v.din;
      if (v.clr) det_hist = 3'b000;
      #2;
      if (v.valid && v.rdy) $display("vec %0d: offering word 0x%02h", i, v.din);
      // Mealy 1010 detector enabled by bit_tick && ser_valid
      det_y = m_sv && bit_tick && ({det_hist, m_ser} == 4'b1010);
      chk($sformatf("v%0d ready", i), m_ready, v.rdy);
      chk($sformatf("v%0d ser_valid", i), m_sv, v.sv);
      chk($sformatf("v%0d ser_out msb", i), m_ser, v.ser);
      chk($sformatf("v%0d ser_out lsb", i), l_ser, v.lsb);
      chk($sformatf("v%0d frame_start", i), m_fs, v.fs);
      chk($sformatf("v%0d frame_end", i), m_fe, v.fe);
      chk($sformatf("v%0d words_sent", i), m_ws, v.ws);
      chk($sformatf("v%0d detector y", i), det_y, v.y);
      if (m_sv && bit_tick) det_hist = {det_hist[1:0], m_ser};
    end

    // Gapped tick: 0xF0 with bit_tick high every third clock
    cyc();
    data_valid = 1'b1; data_in = 8'hF0; bit_tick = 1'b0;
    #2;
    chk("gap accept ready", m_ready, 1'b1);
    $display("gapped: offering word 0xf0");
    for (int k = 0; k < 24; k++) begin
      cyc();
      data_valid = 1'b0; data_in = 8'h00; bit_tick = ((k % 3) == 2);
      #2;
      chk($sformatf("gap c%0d ser_valid", k), m_sv, 1'b1);
      chk($sformatf("gap c%0d ser_out", k), m_ser, (k < 12) ? 1'b1 : 1'b0);
      chk($sformatf("gap c%0d ready", k), m_ready, (k == 23) ? 1'b1 : 1'b0);
    end
    cyc();
    bit_tick = 1'b1;
    #2;
    chk("gap end ser_valid", m_sv, 1'b0);
    chk("gap end words_sent", m_ws, 16'd5);

    // Reset mid-word: abandon 0xFF at bit_cnt=3, then send 0x3C
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    data_valid = 1'b1; data_in = 8'hFF; bit_tick = 1'b1;
    #2;
    chk("rst-mid accept ready", m_ready, 1'b1);
    $display("reset-mid: offering word 0xff");
    for (int k = 0; k < 3; k++) begin
      cyc();
      data_valid = 1'b0;
    end
    cyc();
    reset = 1'b1;
    #2;
    chk("rst-mid ser_valid before reset", m_sv, 1'b1);
    chk("rst-mid ready during reset", m_ready, 1'b0);
    cyc();
    reset = 1'b0; data_valid = 1'b1; data_in = 8'h3C;
    #2;
    chk("rst-mid ser_valid after", m_sv, 1'b0);
    chk("rst-mid ser_out after", m_ser, 1'b0);
    chk("rst-mid words_sent after", m_ws, 16'd0);
    chk("rst-mid ready after", m_ready, 1'b1);
    $display("reset-mid: offering word 0x3c");
    for (int k = 0; k < 8; k++) begin
      logic [7:0] w;
      w = 8'h3C;
      cyc();
      data_valid = 1'b0; data_in = 8'h00;
      #2;
      chk($sformatf("3c bit%0d ser_out", k), m_ser, w[7-k]);
      chk($sformatf("3c bit%0d frame_end", k), m_fe, (k == 7) ? 1'b1 : 1'b0);
    end
    cyc();
    #2;
    chk("3c done ser_valid", m_sv, 1'b0);
    chk("3c done words_sent", m_ws, 16'd1);

    // Counter wrap on the CNT_W=4 instance: 17 back-to-back words
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k <= 137; k++) begin
      cyc();
      data_valid = (k <= 128); data_in = 8'h55; bit_tick = 1'b1;
      #2;
      if ((k % 8) == 0 && k <= 128) $display("wrap: word %0d offered", k / 8 + 1);
      if (k == 121) chk("wrap ws after 15", w_ws, 4'd15);
      if (k == 128) chk("wrap ws before 16th done", w_ws, 4'd15);
      if (k == 129) chk("wrap ws after 16", w_ws, 4'd0);
      if (k == 137) begin
        chk("wrap ws after 17", w_ws, 4'd1);
        chk("wide ws after 17", m_ws, 16'd17);
        chk("wrap idle ser_valid", w_sv, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bit_serializer_piso.md
Name: bit_serializer_piso

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the team's 1010 Mealy sequence detector.
- Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per enabled clock on ser_out, which drives the detector's serial input.
- Supports gapless back-to-back words, so bit patterns spanning a word boundary reach the detector intact.
- Provides frame markers and a sent-word counter.

Parameters:
- WIDTH, 8: word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- IDLE_BIT, 0: level driven on ser_out while no word is in flight.
- CNT_W, 16: width of the words_sent counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word to transmit.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  block can accept a word this cycle.
- bit_tick  input  1  bit-rate enable; tie high for one bit per clk.
- ser_out  output  1  serial bit; connects to the detector's inp.
- ser_valid  output  1  ser_out carries a data bit.
- frame_start  output  1  first bit of a word is on ser_out.
- frame_end  output  1  last bit of a word is on ser_out.
- words_sent  output  CNT_W  count of fully transmitted words, wraps.

Behaviour:
- Reset is synchronous, active-high on clock clk.
  - While reset is high: data_ready=0.
  - After the reset edge: state=IDLE, ser_out=IDLE_BIT, ser_valid=0, bit_cnt=0, words_sent=0.
- States:
  - IDLE: ser_valid=0, ser_out=IDLE_BIT, data_ready=1.
  - SHIFT: ser_valid=1, ser_out = current bit of the shift register.
- data_ready is combinational and is 1 when either:
  - state==IDLE, or
  - state==SHIFT and bit_cnt==WIDTH-1 and bit_tick==1.
- Accept: data_valid && data_ready && !reset at a rising edge.
  - Load the shift register from data_in; set bit_cnt=0; state=SHIFT.
  - The first bit appears on ser_out in the cycle after acceptance (latency 1 clk).
- In SHIFT with bit_tick=0: all state holds and the current bit stays on ser_out.
- In SHIFT with bit_tick=1 and bit_cnt<WIDTH-1: shift by one toward the output end (MSB or LSB per MSB_FIRST) and increment bit_cnt.
- In SHIFT with bit_tick=1 and bit_cnt==WIDTH-1:
  - words_sent increments, wrapping modulo 2^CNT_W.
  - If data_valid=1: load the new word, bit_cnt=0, stay in SHIFT. There is no idle gap between words.
  - Else: go to IDLE; ser_out=IDLE_BIT and ser_valid=0 from the next cycle.
- frame_start = SHIFT && bit_cnt==0; frame_end = SHIFT && bit_cnt==WIDTH-1. Both are decoded from registers, with no combinational path from inputs.
- Each bit occupies ser_out from the edge that presents it until, and including, the cycle in which bit_tick is sampled high.
- data_in and data_valid are ignored whenever data_ready=0. Holding data_valid high without ready has no side effect.
- Reset mid-word: the word is abandoned and not counted. The next cycle shows IDLE outputs, with data_ready=1 once reset is low.
- The downstream detector samples ser_out on every clk. With bit_tick tied high, every clk carries one valid bit. With a gapped bit_tick, the detector must be enabled by bit_tick && ser_valid.

Decomposition:
- Shared package:
  - State typedef (ST_IDLE, ST_SHIFT).
  - Default WIDTH and CNT_W constants.
  - IDLE_BIT default.
- One natural sub-module: bit_serializer_counter.
  - Contains the $clog2(WIDTH)-bit bit_cnt with its last-bit decode.
  - Contains the CNT_W-bit words_sent counter.
- Shift register and FSM stay in the top module.

Test Plan:
- MSB-first single word: WIDTH=8, MSB_FIRST=1, bit_tick=1, send 0xA5.
  - data_ready drops the cycle after acceptance.
  - ser_out = 1,0,1,0,0,1,0,1 over the next 8 cycles.
  - frame_start on bit 1, frame_end on bit 8.
  - IDLE_BIT and ser_valid=0 afterwards; words_sent=1.
- Back-to-back words: data_valid held high with 0x0A then 0x0A.
  - 16 consecutive valid bits 0000101000001010 with no gap.
  - data_ready is high only on the cycles carrying bits 8 and 16.
  - The chained 1010 detector asserts y exactly twice, on bits 8 and 16.
- LSB-first: MSB_FIRST=0, send 0x01.
  - ser_out = 1,0,0,0,0,0,0,0.
- Gapped tick: bit_tick high every 3rd clk, send 0xF0.
  - Each bit is held for 3 clks; total 24 clks of ser_valid.
  - data_ready does not assert before the 3rd clk of the last bit.
- Reset mid-word: reset pulses while bit_cnt=3.
  - Next cycle: ser_valid=0, ser_out=IDLE_BIT, words_sent unchanged.
  - A new word of 0x3C is then accepted normally.
- Counter wrap: CNT_W=4, send 17 words.
  - words_sent goes 15 -> 0 -> 1.
